fwrisc_dbg_trace_fifo: RTL

- Consumes the per-instruction retirement record that the debug-BFM wrapper presents to the RISC-V debug BFM: valid, pc, instr, intr, iret, rd, and memory fields.
- Buffers accepted records in a circular FIFO and drains them over a valid/ready stream to a host or trace sink.
- Supports stop-on-full or overwrite-oldest modes, an overflow counter, and a PC-match stop trigger for post-mortem capture.

---
 rtl/fwrisc_dbg_trace_fifo_if.sv | 40 ++++
 rtl/fwrisc_dbg_trace_fifo.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/fwrisc_dbg_trace_fifo_if.sv
// Trace FIFO bus: the retirement record coming in from the debug-BFM wrapper
// and the first-word-fall-through record stream going out to the trace sink.
interface fwrisc_dbg_trace_fifo_if;
  logic        valid;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        intr;
  logic        iret;
  logic [4:0]  rd_addr;
  logic [31:0] rd_wdata;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_data;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [31:0] out_rd_wdata;
  logic [31:0] out_mem_addr;
  logic [31:0] out_mem_data;
  logic [4:0]  out_rd_addr;
  logic [9:0]  out_flags;

  // Master is the wrapper/host side; it produces records and consumes the stream.
  modport master (
    output valid, pc, instr, intr, iret, rd_addr, rd_wdata,
           mem_addr, mem_rmask, mem_wmask, mem_data, out_ready,
    input  out_valid, out_pc, out_instr, out_rd_wdata, out_mem_addr,
           out_mem_data, out_rd_addr, out_flags
  );

  modport slave (
    input  valid, pc, instr, intr, iret, rd_addr, rd_wdata,
           mem_addr, mem_rmask, mem_wmask, mem_data, out_ready,
    output out_valid, out_pc, out_instr, out_rd_wdata, out_mem_addr,
           out_mem_data, out_rd_addr, out_flags
  );
endinterface

// File: rtl/fwrisc_dbg_trace_fifo.sv
// Retirement trace FIFO: captures per-instruction records into a circular buffer
// with drop/overwrite on full, an overflow counter and a sticky PC-match stop trigger.
module fwrisc_dbg_trace_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter bit OVERWRITE  = 1'b0
) (
  input  logic                    clock,
  input  logic                    reset,
  fwrisc_dbg_trace_fifo_if.slave  bus,
  input  logic                    cap_en,
  input  logic                    clear,
  input  logic                    trig_en,
  input  logic [31:0]             trig_pc,
  output logic [DEPTH_LOG2:0]     count,
  output logic                    full,
  output logic [15:0]             ovf_count,
  output logic                    triggered
);

  localparam int                    DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   CNT_ZERO  = (DEPTH_LOG2 + 1)'(0);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO  = DEPTH_LOG2'(0);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_STOPPED = 1'b1
  } state_t;

  // 175-bit record; field order fixes the storage layout.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        intr;
    logic        iret;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_data;
  } rec_t;

  state_t                state_r;
  logic [DEPTH_LOG2-1:0] head_r;
  logic [DEPTH_LOG2-1:0] tail_r;
  logic [DEPTH_LOG2:0]   count_r;
  logic [15:0]           ovf_r;
  logic                  trig_r;
  rec_t                  mem_r [DEPTH];

  logic full_s, push_s, pop_s, ovf_s, wr_s, evict_s, inc_s, dec_s, hit_s, flush_s;
  rec_t wr_rec_s;
  rec_t rd_rec_s;

  // Push/pop decode and the incoming record.
  always_comb begin
    flush_s  = reset || clear;
    full_s   = (count_r == DEPTH_CNT);
    push_s   = bus.valid && cap_en && (state_r == ST_RUN);
    pop_s    = (count_r != CNT_ZERO) && bus.out_ready;
    // A pop in the same cycle frees a slot, so only push-without-pop on full overflows.
    ovf_s    = push_s && full_s && !pop_s;
    wr_s     = push_s && (!ovf_s || OVERWRITE);
    evict_s  = ovf_s && OVERWRITE;
    inc_s    = push_s && !full_s && !pop_s;
    dec_s    = pop_s && !push_s;
    hit_s    = push_s && trig_en && (bus.pc == trig_pc);
    wr_rec_s = '{pc: bus.pc, instr: bus.instr, intr: bus.intr, iret: bus.iret,
                 rd_addr: bus.rd_addr, rd_wdata: bus.rd_wdata, mem_addr: bus.mem_addr,
                 mem_rmask: bus.mem_rmask, mem_wmask: bus.mem_wmask,
                 mem_data: bus.mem_data};
  end

  // Record storage; flush takes priority over a concurrent write.
  always_ff @(posedge clock) begin
    if (wr_s && !flush_s) begin
      mem_r[tail_r] <= wr_rec_s;
    end
  end

  // Pointers, occupancy, overflow counter and the run/stopped trigger FSM.
  always_ff @(posedge clock) begin
    if (flush_s) begin
      head_r  <= PTR_ZERO;
      tail_r  <= PTR_ZERO;
      count_r <= CNT_ZERO;
      ovf_r   <= 16'h0000;
      trig_r  <= 1'b0;
      state_r <= ST_RUN;
    end else begin
      if (wr_s) begin
        tail_r <= tail_r + PTR_ONE;
      end
      if (pop_s || evict_s) begin
        head_r <= head_r + PTR_ONE;
      end
      if (inc_s) begin
        count_r <= count_r + CNT_ONE;
      end else if (dec_s) begin
        count_r <= count_r - CNT_ONE;
      end
      if (ovf_s && (ovf_r != 16'hFFFF)) begin
        ovf_r <= ovf_r + 16'h0001;
      end
      case (state_r)
        ST_RUN: begin
          if (hit_s) begin
            state_r <= ST_STOPPED;
            trig_r  <= 1'b1;
          end
        end
        ST_STOPPED: begin
          state_r <= ST_STOPPED;
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  // First-word fall-through head view, zeroed while empty.
  always_comb begin
    rd_rec_s = mem_r[head_r];
    if (count_r != CNT_ZERO) begin
      bus.out_valid    = 1'b1;
      bus.out_pc       = rd_rec_s.pc;
      bus.out_instr    = rd_rec_s.instr;
      bus.out_rd_wdata = rd_rec_s.rd_wdata;
      bus.out_mem_addr = rd_rec_s.mem_addr;
      bus.out_mem_data = rd_rec_s.mem_data;
      bus.out_rd_addr  = rd_rec_s.rd_addr;
      bus.out_flags    = {rd_rec_s.intr, rd_rec_s.iret, rd_rec_s.mem_rmask, rd_rec_s.mem_wmask};
    end else begin
      bus.out_valid    = 1'b0;
      bus.out_pc       = 32'h0000_0000;
      bus.out_instr    = 32'h0000_0000;
      bus.out_rd_wdata = 32'h0000_0000;
      bus.out_mem_addr = 32'h0000_0000;
      bus.out_mem_data = 32'h0000_0000;
      bus.out_rd_addr  = 5'd0;
      bus.out_flags    = 10'd0;
    end
  end

  assign count     = count_r;
  assign full      = full_s;
  assign ovf_count = ovf_r;
  assign triggered = trig_r;

endmodule
